// File: rtl/isa_pkg.sv
// Shared ISA definitions for the fetch/decode stage and the ALU: field positions,
// opcode enums, the reserved halt word, the sequencer state type and control decode.
package isa_pkg;

  localparam int WORD_W   = 9;
  localparam int TYPE_BIT = 8;
  localparam int ROP_HI   = 7;
  localparam int ROP_LO   = 4;
  localparam int IOP_HI   = 7;
  localparam int IOP_LO   = 5;
  localparam int IMM_HI   = 4;
  localparam int IMM_LO   = 0;
  localparam int SEL_HI   = 3;
  localparam int SEL_LO   = 0;
  localparam int LUT_SIZE = 16;

  localparam logic TYPE_R = 1'b0;
  localparam logic TYPE_I = 1'b1;

  // J through LUT entry 15; that entry therefore never holds a real target.
  localparam logic [WORD_W-1:0] HALT_WORD = 9'b0_1101_1111;

  typedef enum logic [3:0] {
    R_ADD = 4'b0000,
    R_SUB = 4'b0001,
    R_AND = 4'b0010,
    R_OR  = 4'b0011,
    R_XOR = 4'b0100,
    R_SHL = 4'b0101,
    R_SHR = 4'b0110,
    R_NOT = 4'b0111,
    R_LW  = 4'b1000,
    R_SW  = 4'b1001,
    R_MOV = 4'b1010,
    R_CLR = 4'b1011,
    R_BR  = 4'b1100,
    R_J   = 4'b1101,
    R_SET = 4'b1110,
    R_GET = 4'b1111
  } r_op_e;

  typedef enum logic [2:0] {
    I_ADDI = 3'b000,
    I_SUBI = 3'b001,
    I_ANDI = 3'b010,
    I_ORI  = 3'b011,
    I_SHLI = 3'b100,
    I_SHRI = 3'b101,
    I_NOP6 = 3'b110,
    I_NOP7 = 3'b111
  } i_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } fsm_state_e;

  typedef struct packed {
    logic accWe;
    logic regWe;
    logic memRead;
    logic memWrite;
  } ctrl_t;

  // Write-back and memory enables implied by an instruction word, ignoring FSM state.
  function automatic ctrl_t decodeCtrl(input logic [WORD_W-1:0] word);
    ctrl_t c;
    r_op_e rop;
    i_op_e iop;
    c   = '0;
    rop = r_op_e'(word[ROP_HI:ROP_LO]);
    iop = i_op_e'(word[IOP_HI:IOP_LO]);
    if (word[TYPE_BIT] == TYPE_I) begin
      c.accWe = !(iop inside {I_NOP6, I_NOP7});
    end else begin
      case (rop)
        R_LW: begin
          c.accWe   = 1'b1;
          c.memRead = 1'b1;
        end
        R_SW:       c.memWrite = 1'b1;
        R_SET:      c.regWe    = 1'b1;
        R_BR, R_J:  c          = '0;
        default:    c.accWe    = 1'b1;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/branch_lut.sv
// Fixed 16-entry branch/jump target table indexed by the instruction's register select.
module branch_lut
  import isa_pkg::*;
#(
  parameter int PC_W = 10
) (
  input  logic [SEL_HI-SEL_LO:0] regSel,
  output logic [PC_W-1:0]        target
);

  logic [9:0] raw;

  always_comb begin
    raw = '0;
    case (regSel)
      4'd0:    raw = 10'd10;
      4'd1:    raw = 10'd20;
      4'd2:    raw = 10'd40;
      4'd3:    raw = 10'd60;
      4'd4:    raw = 10'd7;
      4'd5:    raw = 10'd100;
      4'd6:    raw = 10'd200;
      4'd7:    raw = 10'd300;
      4'd8:    raw = 10'd400;
      4'd9:    raw = 10'd500;
      4'd10:   raw = 10'd600;
      4'd11:   raw = 10'd700;
      4'd12:   raw = 10'd800;
      4'd13:   raw = 10'd900;
      4'd14:   raw = 10'd1020;
      default: raw = 10'd0;  // entry 15 is reserved by the halt word
    endcase
    // Narrower PCs keep the low bits of each target.
    target = PC_W'(raw);
  end

endmodule

// File: rtl/fetch_decode.sv
// Instruction fetch, program counter and decode stage: drives the PC to instruction
// memory, splits the returned word into ALU control fields and sequences IDLE/RUN/DONE.
module fetch_decode
  import isa_pkg::*;
#(
  parameter int PC_W = 10
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [WORD_W-1:0]          imem_data,
  input  logic                       aluBranch,
  output logic [PC_W-1:0]            imem_addr,
  output logic                       typeCode,
  output logic [ROP_HI-ROP_LO:0]     rOp,
  output logic [IOP_HI-IOP_LO:0]     iOp,
  output logic [IMM_HI-IMM_LO:0]     imm,
  output logic [SEL_HI-SEL_LO:0]     regSel,
  output logic                       accWe,
  output logic                       regWe,
  output logic                       memRead,
  output logic                       memWrite,
  output logic                       done
);

  fsm_state_e      state, stateNext;
  logic [PC_W-1:0] pc, pcNext;
  logic [PC_W-1:0] lutTarget;
  ctrl_t           decCtrl, ctrl;
  logic            isHalt, isJump, isBranch;

  assign typeCode = imem_data[TYPE_BIT];
  assign rOp      = imem_data[ROP_HI:ROP_LO];
  assign iOp      = imem_data[IOP_HI:IOP_LO];
  assign imm      = imem_data[IMM_HI:IMM_LO];
  assign regSel   = imem_data[SEL_HI:SEL_LO];

  assign decCtrl  = decodeCtrl(imem_data);
  assign isHalt   = (imem_data == HALT_WORD);
  assign isJump   = (typeCode == TYPE_R) && (r_op_e'(rOp) == R_J);
  assign isBranch = (typeCode == TYPE_R) && (r_op_e'(rOp) == R_BR);

  branch_lut #(.PC_W(PC_W)) u_branchLut (
    .regSel (regSel),
    .target (lutTarget)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values; the async reset sits in the sensitivity list.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      pc    <= '0;
    end else begin
      state <= stateNext;
      pc    <= pcNext;
    end
  end

  // NOTE: every signal written here gets a default first, so no path infers a latch.
  always_comb begin
    stateNext = state;
    pcNext    = pc;
    ctrl      = '0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          stateNext = S_RUN;
          pcNext    = '0;
        end
      end
      S_RUN: begin
        if (isHalt) begin
          stateNext = S_DONE;
        end else begin
          ctrl = decCtrl;
          if (isJump || (isBranch && aluBranch)) pcNext = lutTarget;
          else                                   pcNext = pc + PC_W'(1);
        end
      end
      default: begin
        stateNext = S_IDLE;
        pcNext    = '0;
      end
    endcase
  end

  assign imem_addr = pc;
  assign done      = (state == S_DONE);
  assign accWe     = ctrl.accWe;
  assign regWe     = ctrl.regWe;
  assign memRead   = ctrl.memRead;
  assign memWrite  = ctrl.memWrite;

endmodule

// File: tb/tb_fetch_decode.sv
// Self-checking bench for fetch_decode: directed scenarios with literal expectations,
// then randomized programs checked every cycle against a behavioural model.
module tb_fetch_decode;

  localparam int PC_W = 10;
  localparam int DEPTH = 1 << PC_W;
  localparam logic [8:0] HALT = 9'b0_1101_1111;
  localparam logic [8:0] ADD  = 9'b0_0000_0000;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic            aluBranch = 1'b0;
  logic [8:0]      imem_data;
  logic [PC_W-1:0] imem_addr;
  logic            typeCode;
  logic [3:0]      rOp;
  logic [2:0]      iOp;
  logic [4:0]      imm;
  logic [3:0]      regSel;
  logic            accWe, regWe, memRead, memWrite, done;

  logic [8:0] imem [DEPTH];
  int lutTab [16] = '{10, 20, 40, 60, 7, 100, 200, 300, 400, 500, 600, 700, 800, 900, 1020, 0};

  int total = 0;
  int bad = 0;
  bit checkOn = 1'b0;

  // model: mode 0 = idle, 1 = run, 2 = done
  int mMode = 0;
  int mPc = 0;

  assign imem_data = imem[imem_addr];

  always #5 clk = ~clk;

  fetch_decode #(.PC_W(PC_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .imem_data (imem_data),
    .aluBranch (aluBranch),
    .imem_addr (imem_addr),
    .typeCode  (typeCode),
    .rOp       (rOp),
    .iOp       (iOp),
    .imm       (imm),
    .regSel    (regSel),
    .accWe     (accWe),
    .regWe     (regWe),
    .memRead   (memRead),
    .memWrite  (memWrite),
    .done      (done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] enables();
    return {accWe, regWe, memRead, memWrite};
  endfunction

  // Behavioural model of the sequencer, stepped on the same edge as the DUT.
  always @(posedge clk or posedge reset) begin
    logic [8:0] w;
    if (reset) begin
      mMode = 0;
      mPc   = 0;
    end else begin
      w = imem[mPc];
      if (mMode == 1) begin
        if (w == HALT) mMode = 2;
        else if (w[8] == 1'b0 && (w[7:4] == 4'd13 || (w[7:4] == 4'd12 && aluBranch)))
          mPc = lutTab[w[3:0]] % DEPTH;
        else
          mPc = (mPc + 1) % DEPTH;
      end else if (start) begin
        mMode = 1;
        mPc   = 0;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic [8:0] w;
    logic       run, t;
    logic [3:0] op4;
    logic [2:0] op3;
    logic [3:0] expEn;
    if (checkOn) begin
      w   = imem[mPc];
      run = (mMode == 1) && (w != HALT);
      t   = w[8];
      op4 = w[7:4];
      op3 = w[7:5];
      expEn[3] = run && (t ? (op3 < 3'd6)
                           : (op4 <= 4'd8 || op4 == 4'd10 || op4 == 4'd11 || op4 == 4'd15));
      expEn[2] = run && !t && op4 == 4'd14;
      expEn[1] = run && !t && op4 == 4'd8;
      expEn[0] = run && !t && op4 == 4'd9;
      check("model_addr", 32'(imem_addr), 32'(mPc));
      check("model_done", 32'(done), 32'(mMode == 2));
      check("model_enables", 32'(enables()), 32'(expEn));
      check("model_fields", {15'd0, typeCode, rOp, iOp, imm, regSel},
            {15'd0, w[8], w[7:4], w[7:5], w[4:0], w[3:0]});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) imem[i] = ADD;
    imem[0]  = 9'b1_000_11111;  // ADDI 31
    imem[1]  = 9'b0_1001_0011;  // SW r3
    imem[2]  = 9'b0_1100_0010;  // BR via LUT[2]
    imem[40] = 9'b0_1100_0010;  // BR via LUT[2]
    imem[41] = 9'b0_1101_0100;  // J via LUT[4]

    repeat (2) tick();
    reset = 1'b0;
    checkOn = 1'b1;
    check("reset_addr", 32'(imem_addr), 0);
    check("reset_done", 32'(done), 0);
    check("reset_en", 32'(enables()), 0);

    pulseStart();
    check("addi_addr", 32'(imem_addr), 0);
    check("addi_fields", {28'd0, typeCode, iOp}, {28'd0, 1'b1, 3'b000});
    check("addi_imm", 32'(imm), 31);
    check("addi_en", 32'(enables()), 32'(4'b1000));

    tick();
    check("sw_addr", 32'(imem_addr), 1);
    check("sw_regsel", 32'(regSel), 3);
    check("sw_en", 32'(enables()), 32'(4'b0001));
    aluBranch = 1'b1;

    tick();
    check("br_en", 32'(enables()), 0);
    tick();
    check("br_taken_addr", 32'(imem_addr), 40);
    aluBranch = 1'b0;
    tick();
    check("br_not_taken_addr", 32'(imem_addr), 41);
    aluBranch = 1'($urandom_range(1));
    check("j_en", 32'(enables()), 0);
    tick();
    check("j_addr", 32'(imem_addr), 7);
    aluBranch = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_in_run_addr", 32'(imem_addr), 8);
    check("start_in_run_done", 32'(done), 0);

    // Asynchronous reset in the middle of RUN at PC 5.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    pulseStart();
    repeat (5) tick();
    check("pre_reset_addr", 32'(imem_addr), 5);
    #2 reset = 1'b1;
    #1;
    check("async_reset_addr", 32'(imem_addr), 0);
    check("async_reset_done", 32'(done), 0);
    check("async_reset_en", 32'(enables()), 0);
    @(negedge clk);
    #1 reset = 1'b0;
    tick();
    check("idle_addr", 32'(imem_addr), 0);
    pulseStart();
    check("restart_addr", 32'(imem_addr), 0);
    check("restart_en", 32'(enables()), 32'(4'b1000));

    // Wrap past the top address via J to LUT[14] = 1020.
    imem[1] = 9'b0_1101_1110;
    tick();
    tick();
    check("j14_addr", 32'(imem_addr), 1020);
    repeat (3) tick();
    check("top_addr", 32'(imem_addr), 1023);
    imem[1] = 9'b0_1001_0011;
    imem[3] = HALT;
    tick();
    check("wrap_addr", 32'(imem_addr), 0);

    // Halt at address 3, hold in DONE, restart.
    repeat (3) tick();
    check("halt_decode_addr", 32'(imem_addr), 3);
    check("halt_decode_en", 32'(enables()), 0);
    check("halt_decode_done", 32'(done), 0);
    tick();
    check("done_rise", 32'(done), 1);
    check("done_addr", 32'(imem_addr), 3);
    repeat (2) tick();
    check("done_hold", 32'(done), 1);
    check("done_hold_addr", 32'(imem_addr), 3);
    check("done_en", 32'(enables()), 0);
    pulseStart();
    check("done_restart_done", 32'(done), 0);
    check("done_restart_addr", 32'(imem_addr), 0);

    // Randomized programs, branch flags, start pulses and occasional resets.
    reset = 1'b1;
    tick();
    for (int i = 0; i < DEPTH; i++)
      imem[i] = ($urandom_range(39) == 0) ? HALT : 9'($urandom);
    reset = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      aluBranch = 1'($urandom_range(1));
      start = ($urandom_range(15) == 0);
      if ($urandom_range(399) == 0) begin
        #2 reset = 1'b1;
        @(negedge clk);
        #1 reset = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
